// File: rtl/instr_fetch_unit.sv
// Fetch/stage front end: instruction RAM, PC, stage register and fetch FSM with
// a valid/ready issue port, branch redirect, HALT and a RAM clear sweep.
// Optional: define IFU_BREAKPOINT_EN to add the bp_en/bp_addr fetch breakpoint.
module instr_fetch_unit #(
  parameter int               OPC_W    = 5,
  parameter int               MODE_W   = 3,
  parameter int               OPR_W    = 8,
  parameter int               ADDR_W   = 8,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'h1F
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                ram_clr,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [OPC_W+MODE_W+OPR_W-1:0] ld_data,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_target,
`ifdef IFU_BREAKPOINT_EN
  input  logic                bp_en,
  input  logic [ADDR_W-1:0]   bp_addr,
`endif
  input  logic                out_ready,
  output logic                out_valid,
  output logic [OPC_W-1:0]    opcode,
  output logic [MODE_W-1:0]   mode,
  output logic [OPR_W-1:0]    operand,
  output logic [ADDR_W-1:0]   pc,
  output logic                halted,
  output logic                busy
);

  localparam int INSTR_W = OPC_W + MODE_W + OPR_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  // Issue handshake: the staged word is transferred on a cycle where
  // out_valid && out_ready; out_valid and fields hold stable until then.
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_LATCH, S_ISSUE, S_HALT
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    sweep_q, sweep_d;
  logic [INSTR_W-1:0]   stage_q, stage_d;
  logic                 valid_q, valid_d;
  logic                 armed_q, armed_d;
  logic [INSTR_W-1:0]   rd_data_q;
  logic                 rd_en;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [INSTR_W-1:0]   mem_wdata;
  logic [INSTR_W-1:0]   mem [DEPTH];
`ifdef IFU_BREAKPOINT_EN
  logic                 skip_q, skip_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    sweep_d   = sweep_q;
    stage_d   = stage_q;
    valid_d   = valid_q;
    armed_d   = armed_q;
    rd_en     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = ld_addr;
    mem_wdata = ld_data;
`ifdef IFU_BREAKPOINT_EN
    skip_d    = skip_q;
`endif
    case (state_q)
      S_IDLE: begin
        mem_we = ld_en;
        if (ram_clr) begin
          state_d = S_CLEAR;
          sweep_d = '0;
        end else if (run) begin
          state_d = S_FETCH;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + ADDR_W'(1);
        if (&sweep_q) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
`ifdef IFU_BREAKPOINT_EN
        // The skip flag lets the resumed fetch at the breakpoint go through once.
        if (bp_en && (pc_q == bp_addr) && !skip_q) begin
          state_d = S_HALT;
          skip_d  = 1'b1;
          armed_d = 1'b0;
        end else begin
          rd_en   = 1'b1;
          skip_d  = 1'b0;
          state_d = S_LATCH;
        end
`else
        rd_en   = 1'b1;
        state_d = S_LATCH;
`endif
      end
      S_LATCH: begin
        stage_d = rd_data_q;
        valid_d = 1'b1;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (br_taken) pc_d = br_target;
          if (stage_q[INSTR_W-1 -: OPC_W] == HALT_OPC) begin
            state_d = S_HALT;
            armed_d = 1'b0;
          end else if (!run) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        // Resume needs run low then high while halted; armed_q records the low.
        mem_we = ld_en;
        if (ram_clr) begin
          state_d = S_CLEAR;
          sweep_d = '0;
        end else if (run && armed_q) begin
          state_d = S_FETCH;
        end else if (!run) begin
          armed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sweep_q <= '0;
      stage_q <= '0;
      valid_q <= 1'b0;
      armed_q <= 1'b0;
`ifdef IFU_BREAKPOINT_EN
      skip_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sweep_q <= sweep_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
      armed_q <= armed_d;
`ifdef IFU_BREAKPOINT_EN
      skip_q  <= skip_d;
`endif
    end
  end

  // RAM contents survive reset; a reset cycle suppresses any write.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en) rd_data_q <= mem[pc_q];
  end

  assign out_valid = valid_q;
  assign opcode    = stage_q[INSTR_W-1 -: OPC_W];
  assign mode      = stage_q[OPR_W +: MODE_W];
  assign operand   = stage_q[OPR_W-1:0];
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign busy      = (state_q == S_CLEAR);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised fetch/stage front end for the accumulator CPU.
- Merges the instruction RAM, program counter, stage register and fetch controller into one block with a valid/ready issue handshake, branch redirect, HALT detection and a hardware RAM-clear sweep.
- Sits between the program loader and the CPU execute stage.
- Replaces separately wired RAM/PC/stage-register instances driven by discrete enable strobes.

Parameters:
- OPC_W, 5, opcode field width (instruction MSBs).
- MODE_W, 3, addressing-mode field width.
- OPR_W, 8, operand field width (instruction LSBs); INSTR_W = OPC_W+MODE_W+OPR_W.
- ADDR_W, 8, PC/RAM address width; DEPTH = 2**ADDR_W.
- HALT_OPC, 5'h1F, opcode value that halts fetch.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- run  in  1  start/continue fetching.
- ram_clr  in  1  request clear sweep of instruction RAM.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  load address.
- ld_data  in  INSTR_W  load word.
- br_taken  in  1  redirect PC, sampled on issue acceptance.
- br_target  in  ADDR_W  redirect address.
- out_ready  in  1  execute stage accepts the staged instruction.
- out_valid  out  1  staged instruction valid.
- opcode  out  OPC_W  staged opcode.
- mode  out  MODE_W  staged addressing mode.
- operand  out  OPR_W  staged operand.
- pc  out  ADDR_W  address of the next fetch.
- halted  out  1  in HALT state.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; pc=0; out_valid=0; opcode/mode/operand=0; halted=0; busy=0. RAM contents are preserved. Reset mid-sweep or mid-fetch aborts immediately.
- RAM: DEPTH x INSTR_W, synchronous read with 1-cycle latency, single write port. Writes are accepted only in IDLE or HALT; ld_en in any other state is ignored.
- States and transitions:
  - IDLE:
    - ram_clr=1 -> CLEAR; ram_clr has priority over run.
    - else run=1 -> FETCH.
  - CLEAR:
    - busy=1; writes 0 to address sweep_cnt each cycle, sweep_cnt running 0..DEPTH-1.
    - After the write to DEPTH-1 -> IDLE with busy=0 and pc=0. Duration is exactly DEPTH cycles.
    - ld_en is ignored.
  - FETCH: RAM read at pc -> LATCH.
  - LATCH:
    - RAM data loads the stage register; out_valid=1.
    - pc <= pc+1, modulo DEPTH (DEPTH-1 wraps to 0).
    - -> ISSUE.
  - ISSUE:
    - Outputs are held stable while out_ready=0.
    - On out_ready=1: out_valid drops next cycle.
      - If br_taken=1: pc <= br_target (overrides the increment).
      - If opcode==HALT_OPC -> HALT.
      - Else if run=0 -> IDLE.
      - Else -> FETCH.
  - HALT:
    - halted=1; out_valid=0.
    - run 1->0->1 (a rising edge seen while in HALT) -> FETCH at the current pc.
    - ram_clr -> CLEAR.
- Throughput: one instruction per 3 cycles when out_ready is held high. First out_valid appears 2 cycles after run is sampled in IDLE.
- br_taken outside an ISSUE acceptance cycle is ignored.
- A HALT instruction is still issued (valid/ready) before halting. br_taken on that acceptance still updates pc.
- A load to the address currently being fetched takes effect on the next fetch only; it cannot occur in practice because loads are gated by state.

Optional Feature:
- Macro IFU_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_en (in, 1) and bp_addr (in, ADDR_W).
  - In FETCH, if bp_en=1 and pc==bp_addr, no read occurs and the unit enters HALT with halted=1.
  - Resume via the HALT run edge re-fetches bp_addr once without re-triggering. A one-shot skip flag is cleared after that fetch.
- Undefined: the ports are absent; FETCH always reads.

Test Plan:
- Load ADDR 0..2 = 16'h0812, 16'h1034, 16'hF800; run=1, out_ready=1 -> issues opcode 1/mode 0/operand 0x12, then opcode 2/operand 0x34, then opcode 0x1F; halted=1; pc=3.
- Issue of addr 1 with br_taken=1, br_target=0x40 -> next issue comes from 0x40; pc=0x41 after that LATCH.
- out_ready=0 for 5 cycles in ISSUE -> out_valid and fields stable all 5 cycles; pc unchanged; no further RAM reads.
- ADDR_W=4, pc=15, run=1 -> fetch 15, then pc=0; the next issue comes from addr 0.
- ram_clr in IDLE -> busy=1 for exactly 16 cycles (ADDR_W=4); afterwards every address reads 0. reset=0 at sweep cycle 7 -> busy=0 next edge; addresses 7..15 retain their old data.
- IFU_BREAKPOINT_EN, bp_en=1, bp_addr=2, program without HALT -> halted after issuing addr 1. The run edge resumes with addr 2 issued once, and the unit continues to addr 3.
